// File: rtl/fp_div.sv
// Iterative single-rounding IEEE-754 divider: one restoring quotient bit per cycle, then a round step.
// flags bit order is {NV, DZ, OF, UF, NX}; subnormal operands are flushed to zero.
module fp_div #(
    parameter int unsigned EXPONENT_WIDTH = 8,
    parameter int unsigned FRACTION_WIDTH = 23,
    parameter int unsigned WIDTH          = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       roundingMode,
    input  logic [WIDTH-1:0] fpSrc1,
    input  logic [WIDTH-1:0] fpSrc2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] fpResult,
    output logic [4:0]       flags
);

    localparam int unsigned EW = EXPONENT_WIDTH;
    localparam int unsigned FW = FRACTION_WIDTH;
    localparam int unsigned MW = FW + 1;
    localparam int unsigned RW = FW + 2;
    localparam int unsigned QW = FW + 4;
    localparam int unsigned XW = EW + 2;
    localparam int unsigned CW = $clog2(QW);

    localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EW - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);
    localparam logic [CW-1:0]        LAST    = CW'(QW - 1);

    typedef enum logic [1:0] {StIdle, StSpecial, StDivide, StRound} state_e;

    state_e state_q, state_d;

    logic accept, iterate, finish;

    logic                 sign_q;
    logic [2:0]           rm_q;
    logic signed [XW-1:0] exp_q;
    logic [MW-1:0]        m2_q;
    logic [RW-1:0]        rem_q;
    logic [QW-1:0]        quo_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     spec_res_q;
    logic [4:0]           spec_flg_q;

    // Operand classification
    logic [EW-1:0] e1, e2;
    logic [FW-1:0] f1, f2;
    logic          sign;
    logic          nan1, nan2, inf1, inf2, zero1, zero2;

    assign e1    = fpSrc1[WIDTH-2:FW];
    assign e2    = fpSrc2[WIDTH-2:FW];
    assign f1    = fpSrc1[FW-1:0];
    assign f2    = fpSrc2[FW-1:0];
    assign sign  = fpSrc1[WIDTH-1] ^ fpSrc2[WIDTH-1];
    assign nan1  = (&e1) && (|f1);
    assign nan2  = (&e2) && (|f2);
    assign inf1  = (&e1) && !(|f1);
    assign inf2  = (&e2) && !(|f2);
    assign zero1 = !(|e1);
    assign zero2 = !(|e2);

    logic             is_special;
    logic [WIDTH-1:0] spec_res;
    logic [4:0]       spec_flg;

    always_comb begin
        is_special = 1'b1;
        spec_res   = '0;
        spec_flg   = '0;
        if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
            spec_res = {1'b0, {EW{1'b1}}, 1'b1, {(FW - 1){1'b0}}};
            spec_flg = 5'b10000;
        end else if (inf1) begin
            spec_res = {sign, {EW{1'b1}}, {FW{1'b0}}};
        end else if (zero2) begin
            spec_res = {sign, {EW{1'b1}}, {FW{1'b0}}};
            spec_flg = 5'b01000;
        end else if (zero1 || inf2) begin
            spec_res = {sign, {(WIDTH - 1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    logic signed [XW-1:0] exp_init;
    assign exp_init = $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS;

    // Restoring step: subtract when the partial remainder covers the divisor
    logic [RW-1:0] divisor, rem_sel, rem_next;
    logic [QW-1:0] quo_next;
    logic          ge;

    always_comb begin
        divisor  = {1'b0, m2_q};
        ge       = rem_q >= divisor;
        rem_sel  = ge ? (rem_q - divisor) : rem_q;
        rem_next = {rem_sel[RW-2:0], 1'b0};
        quo_next = {quo_q[QW-2:0], ge};
    end

    // Normalise and round the finished quotient
    logic [FW-1:0]        frac_n, frac_r;
    logic                 g, r, s, inexact, up, carry;
    logic signed [XW-1:0] exp_n, exp_r;
    logic [MW:0]          sum;
    logic [WIDTH-1:0]     round_res;
    logic [4:0]           round_flg;

    always_comb begin
        if (quo_q[QW-1]) begin
            frac_n = quo_q[QW-2:3];
            g      = quo_q[2];
            r      = quo_q[1];
            s      = quo_q[0] | (|rem_q);
            exp_n  = exp_q;
        end else begin
            frac_n = quo_q[QW-3:2];
            g      = quo_q[1];
            r      = quo_q[0];
            s      = |rem_q;
            exp_n  = exp_q - XW'(1);
        end
        inexact = g | r | s;
        case (rm_q)
            3'd1:    up = 1'b0;
            3'd2:    up = sign_q & inexact;
            3'd3:    up = ~sign_q & inexact;
            3'd4:    up = g;
            default: up = g & (r | s | frac_n[0]);
        endcase
        sum    = {2'b01, frac_n} + {{MW{1'b0}}, up};
        carry  = sum[MW];
        frac_r = carry ? sum[FW:1] : sum[FW-1:0];
        exp_r  = exp_n + $signed({{(XW - 1){1'b0}}, carry});
        if (exp_r >= EXP_MAX) begin
            round_res = {sign_q, {EW{1'b1}}, {FW{1'b0}}};
            round_flg = 5'b00101;
        end else if (exp_r[XW-1] || (exp_r == '0)) begin
            round_res = {sign_q, {(WIDTH - 1){1'b0}}};
            round_flg = 5'b00011;
        end else begin
            round_res = {sign_q, exp_r[EW-1:0], frac_r};
            round_flg = {4'b0000, inexact};
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = is_special ? StSpecial : StDivide;
            StDivide:  if (cnt_q == LAST) state_d = StRound;
            StRound:   state_d = StIdle;
            StSpecial: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM: outputs; a start coinciding with done is deliberately dropped
    always_comb begin
        busy    = state_q != StIdle;
        accept  = start && (state_q == StIdle) && !done;
        iterate = state_q == StDivide;
        finish  = (state_q == StRound) || (state_q == StSpecial);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q     <= 1'b0;
            rm_q       <= '0;
            exp_q      <= '0;
            m2_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            spec_res_q <= '0;
            spec_flg_q <= '0;
            done       <= 1'b0;
            fpResult   <= '0;
            flags      <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                sign_q     <= sign;
                rm_q       <= roundingMode;
                exp_q      <= exp_init;
                m2_q       <= {1'b1, f2};
                rem_q      <= {2'b01, f1};
                quo_q      <= '0;
                cnt_q      <= '0;
                spec_res_q <= spec_res;
                spec_flg_q <= spec_flg;
            end
            if (iterate) begin
                rem_q <= rem_next;
                quo_q <= quo_next;
                cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == StRound) begin
                fpResult <= round_res;
                flags    <= round_flg;
            end else if (state_q == StSpecial) begin
                fpResult <= spec_res_q;
                flags    <= spec_flg_q;
            end
        end
    end

endmodule
